// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared state encoding, screen bounds and object geometry for Pong
// Rev 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

  typedef logic signed [10:0] coord_t;

  typedef enum logic [2:0] {
    ST_SERVE     = 3'd0,
    ST_PLAY      = 3'd1,
    ST_POINT     = 3'd2,
    ST_GAME_OVER = 3'd3
  } state_t;

  localparam coord_t H_MIN    = 11'sd144;
  localparam coord_t H_MAX    = 11'sd783;
  localparam coord_t V_MIN    = 11'sd35;
  localparam coord_t V_MAX    = 11'sd515;
  localparam coord_t P1_X     = 11'sd150;
  localparam coord_t P2_X     = 11'sd760;
  localparam coord_t PAD_W    = 11'sd20;
  localparam coord_t PAD_H    = 11'sd40;
  localparam coord_t BALL_SZ  = 11'sd8;
  localparam coord_t PAD_SPD  = 11'sd2;
  localparam coord_t BALL_SPD = 11'sd2;

  localparam coord_t BALL_X_CTR = 11'sd460;
  localparam coord_t BALL_Y_CTR = 11'sd271;
  localparam coord_t PAD_Y_RST  = 11'sd255;

  // Derived limits, kept at 11 bits so all compares stay signed and width-matched
  localparam coord_t PAD_LAST   = PAD_H - 11'sd1;
  localparam coord_t BALL_LAST  = BALL_SZ - 11'sd1;
  localparam coord_t PAD_Y_MAX  = V_MAX - PAD_H + 11'sd1;
  localparam coord_t BALL_Y_MAX = V_MAX - BALL_SZ + 11'sd1;
  localparam coord_t BALL_X_MAX = H_MAX - BALL_SZ + 11'sd1;
  localparam coord_t P1_FACE    = P1_X + PAD_W;
  localparam coord_t P2_HIT_X   = P2_X - BALL_SZ;
  localparam coord_t AI_OFS     = (BALL_SZ >>> 1) - (PAD_H >>> 1);

  localparam logic [5:0] POINT_FRAMES = 6'd60;
  localparam logic [3:0] WIN_SCORE    = 4'd9;

  function automatic logic [9:0] to_pix(input coord_t v);
    return 10'(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_paddle_ctrl.sv
// ============================================================================
// pong_paddle_ctrl : paddle row register, moves PAD_SPD per tick, clamped
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_load,
  output logic [9:0] o_y
);

  logic [9:0] r_y;
  logic [9:0] w_nxt_y;
  coord_t     w_cur;
  coord_t     w_step;

  always_comb begin
    w_cur  = $signed({1'b0, r_y});
    w_step = w_cur;
    if (i_up && !i_down) begin
      w_step = w_cur - PAD_SPD;
    end else if (i_down && !i_up) begin
      w_step = w_cur + PAD_SPD;
    end
    if (w_step < V_MIN) begin
      w_step = V_MIN;
    end else if (w_step > PAD_Y_MAX) begin
      w_step = PAD_Y_MAX;
    end

    w_nxt_y = r_y;
    if (i_load) begin
      w_nxt_y = to_pix(PAD_Y_RST);
    end else if (i_tick) begin
      w_nxt_y = to_pix(w_step);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y <= to_pix(PAD_Y_RST);
    end else begin
      r_y <= w_nxt_y;
    end
  end

  assign o_y = r_y;

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// ============================================================================
// pong_game_ctrl : Pong sequencer - paddles, ball motion, serve and scoring.
// Define PONG_AI_EN to have paddle 2 track the ball instead of up2/down2.
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        up1,
  input  logic        down1,
  input  logic        up2,
  input  logic        down2,
  input  logic        serve,
  output logic [9:0]  paddle1_y,
  output logic [9:0]  paddle2_y,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [15:0] score,
  output logic [2:0]  game_state
);

  state_t     r_state, w_nxt_state;
  logic [9:0] r_ball_x, r_ball_y, w_nxt_x, w_nxt_y;
  logic       r_dx_right, r_dy_down, w_nxt_dx, w_nxt_dy;
  logic       r_serve_right, w_nxt_serve_right;
  logic [3:0] r_score1, r_score2, w_nxt_s1, w_nxt_s2;
  logic [5:0] r_pt_cnt, w_nxt_cnt;
  logic       r_serve_q;

  logic       w_serve_rise;
  logic       w_pad_tick;
  logic       w_pad_load;
  logic       w_p2_up, w_p2_dn;
  logic [9:0] w_p1_y, w_p2_y;

  coord_t     w_bx, w_by, w_nx, w_ny, w_p1, w_p2;
  logic       w_row1, w_row2, w_hit1, w_hit2, w_miss_l, w_miss_r;

  assign w_serve_rise = serve & ~r_serve_q;
  assign w_pad_tick   = frame_tick & (r_state != ST_GAME_OVER);
  assign w_pad_load   = (r_state == ST_GAME_OVER) & w_serve_rise;

  // Candidate move and collision tests against the current paddle rows
  always_comb begin
    w_bx = $signed({1'b0, r_ball_x});
    w_by = $signed({1'b0, r_ball_y});
    w_p1 = $signed({1'b0, w_p1_y});
    w_p2 = $signed({1'b0, w_p2_y});
    w_nx = r_dx_right ? (w_bx + BALL_SPD) : (w_bx - BALL_SPD);
    w_ny = r_dy_down  ? (w_by + BALL_SPD) : (w_by - BALL_SPD);

    w_row1 = ((w_ny + BALL_LAST) >= w_p1) && (w_ny <= (w_p1 + PAD_LAST));
    w_row2 = ((w_ny + BALL_LAST) >= w_p2) && (w_ny <= (w_p2 + PAD_LAST));

    w_hit1 = !r_dx_right && (w_bx >= P1_FACE) && (w_nx < P1_FACE) && w_row1;
    w_hit2 = r_dx_right && ((w_bx + BALL_LAST) < P2_X) &&
             ((w_nx + BALL_LAST) >= P2_X) && w_row2;

    w_miss_l = (w_nx < H_MIN);
    w_miss_r = (w_nx > BALL_X_MAX);
  end

`ifdef PONG_AI_EN
  coord_t w_ai_tgt;

  always_comb begin
    w_ai_tgt = w_by + AI_OFS;
    w_p2_dn  = (w_ai_tgt - w_p2) >= PAD_SPD;
    w_p2_up  = (w_p2 - w_ai_tgt) >= PAD_SPD;
  end
`else
  assign w_p2_up = up2;
  assign w_p2_dn = down2;
`endif

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_x           = r_ball_x;
    w_nxt_y           = r_ball_y;
    w_nxt_dx          = r_dx_right;
    w_nxt_dy          = r_dy_down;
    w_nxt_serve_right = r_serve_right;
    w_nxt_s1          = r_score1;
    w_nxt_s2          = r_score2;
    w_nxt_cnt         = r_pt_cnt;

    case (r_state)
      ST_SERVE: begin
        if (w_serve_rise) begin
          w_nxt_state = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          if (w_ny < V_MIN) begin
            w_nxt_y  = to_pix(V_MIN);
            w_nxt_dy = 1'b1;
          end else if (w_ny > BALL_Y_MAX) begin
            w_nxt_y  = to_pix(BALL_Y_MAX);
            w_nxt_dy = 1'b0;
          end else begin
            w_nxt_y = to_pix(w_ny);
          end

          if (w_hit1) begin
            w_nxt_x  = to_pix(P1_FACE);
            w_nxt_dx = 1'b1;
          end else if (w_hit2) begin
            w_nxt_x  = to_pix(P2_HIT_X);
            w_nxt_dx = 1'b0;
          end else begin
            w_nxt_x = to_pix(w_nx);
            // Next serve heads toward whoever just lost the point
            if (w_miss_l) begin
              w_nxt_s2          = r_score2 + 4'd1;
              w_nxt_serve_right = 1'b0;
              w_nxt_cnt         = 6'd0;
              w_nxt_state       = ST_POINT;
            end else if (w_miss_r) begin
              w_nxt_s1          = r_score1 + 4'd1;
              w_nxt_serve_right = 1'b1;
              w_nxt_cnt         = 6'd0;
              w_nxt_state       = ST_POINT;
            end
          end
        end
      end

      ST_POINT: begin
        if (frame_tick) begin
          if (r_pt_cnt == (POINT_FRAMES - 6'd1)) begin
            if ((r_score1 == WIN_SCORE) || (r_score2 == WIN_SCORE)) begin
              w_nxt_state = ST_GAME_OVER;
            end else begin
              w_nxt_state = ST_SERVE;
              w_nxt_x     = to_pix(BALL_X_CTR);
              w_nxt_y     = to_pix(BALL_Y_CTR);
              w_nxt_dx    = r_serve_right;
            end
          end else begin
            w_nxt_cnt = r_pt_cnt + 6'd1;
          end
        end
      end

      ST_GAME_OVER: begin
        if (w_serve_rise) begin
          w_nxt_state       = ST_SERVE;
          w_nxt_s1          = 4'd0;
          w_nxt_s2          = 4'd0;
          w_nxt_x           = to_pix(BALL_X_CTR);
          w_nxt_y           = to_pix(BALL_Y_CTR);
          w_nxt_dx          = 1'b1;
          w_nxt_serve_right = 1'b1;
        end
      end

      default: begin
        w_nxt_state = ST_SERVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_SERVE;
      r_ball_x      <= to_pix(BALL_X_CTR);
      r_ball_y      <= to_pix(BALL_Y_CTR);
      r_dx_right    <= 1'b1;
      r_dy_down     <= 1'b1;
      r_serve_right <= 1'b1;
      r_score1      <= 4'd0;
      r_score2      <= 4'd0;
      r_pt_cnt      <= 6'd0;
      r_serve_q     <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_ball_x      <= w_nxt_x;
      r_ball_y      <= w_nxt_y;
      r_dx_right    <= w_nxt_dx;
      r_dy_down     <= w_nxt_dy;
      r_serve_right <= w_nxt_serve_right;
      r_score1      <= w_nxt_s1;
      r_score2      <= w_nxt_s2;
      r_pt_cnt      <= w_nxt_cnt;
      r_serve_q     <= serve;
    end
  end

  pong_paddle_ctrl u_pad1 (
    .clk    (clk),
    .rst    (rst),
    .i_tick (w_pad_tick),
    .i_up   (up1),
    .i_down (down1),
    .i_load (w_pad_load),
    .o_y    (w_p1_y)
  );

  pong_paddle_ctrl u_pad2 (
    .clk    (clk),
    .rst    (rst),
    .i_tick (w_pad_tick),
    .i_up   (w_p2_up),
    .i_down (w_p2_dn),
    .i_load (w_pad_load),
    .o_y    (w_p2_y)
  );

  assign paddle1_y  = w_p1_y;
  assign paddle2_y  = w_p2_y;
  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign score      = {4'h0, r_score1, 4'h0, r_score2};
  assign game_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
// tb_pong_game_ctrl : randomized bench with an integer game model for Pong
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0, serve = 1'b0;
  logic [9:0]  paddle1_y, paddle2_y, ball_x, ball_y;
  logic [15:0] score;
  logic [2:0]  game_state;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .up1        (up1),
    .down1      (down1),
    .up2        (up2),
    .down2      (down2),
    .serve      (serve),
    .paddle1_y  (paddle1_y),
    .paddle2_y  (paddle2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score      (score),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: plain integers, directions as +1/-1, state 0..3
  int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_state, m_cnt, m_serve_dir;
  bit m_sq;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1 = 255; m_p2 = 255; m_bx = 460; m_by = 271;
    m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
    m_state = 0; m_cnt = 0; m_serve_dir = 1; m_sq = 1'b0;
  endtask

  function automatic int pad_move(int y, bit u, bit d);
    int t;
    t = y;
    if (u && !d) t = y - 2;
    else if (d && !u) t = y + 2;
    if (t < 35) t = 35;
    if (t > 476) t = 476;
    return t;
  endfunction

  task automatic model_step(input bit fr, input bit u1, input bit d1,
                            input bit u2, input bit d2, input bit sv);
    int op1, op2, oby, st, nx, ny, yy, ydir;
    bit rise, v1, v2, a2u, a2d;
    rise = sv && !m_sq;
    m_sq = sv;
    op1 = m_p1; op2 = m_p2; oby = m_by; st = m_state;
`ifdef PONG_AI_EN
    a2u = (op2 - (oby + 4 - 20)) >= 2;
    a2d = ((oby + 4 - 20) - op2) >= 2;
`else
    a2u = u2; a2d = d2;
`endif
    if (fr && st != 3) begin
      m_p1 = pad_move(op1, u1, d1);
      m_p2 = pad_move(op2, a2u, a2d);
    end
    case (st)
      0: if (rise) m_state = 1;
      1: if (fr) begin
        nx = m_bx + 2 * m_dx;
        ny = m_by + 2 * m_dy;
        yy = ny; ydir = m_dy;
        if (ny < 35) begin yy = 35; ydir = -m_dy; end
        else if (ny > 508) begin yy = 508; ydir = -m_dy; end
        v1 = (ny + 7 >= op1) && (ny <= op1 + 39);
        v2 = (ny + 7 >= op2) && (ny <= op2 + 39);
        if (m_dx < 0 && m_bx >= 170 && nx < 170 && v1) begin
          m_bx = 170; m_dx = 1;
        end else if (m_dx > 0 && m_bx + 7 < 760 && nx + 7 >= 760 && v2) begin
          m_bx = 752; m_dx = -1;
        end else begin
          m_bx = nx;
          if (nx < 144) begin
            m_s2++; m_serve_dir = -1; m_state = 2; m_cnt = 0;
          end else if (nx > 776) begin
            m_s1++; m_serve_dir = 1; m_state = 2; m_cnt = 0;
          end
        end
        m_by = yy; m_dy = ydir;
      end
      2: if (fr) begin
        if (m_cnt == 59) begin
          if (m_s1 == 9 || m_s2 == 9) m_state = 3;
          else begin
            m_state = 0; m_bx = 460; m_by = 271; m_dx = m_serve_dir;
          end
        end else m_cnt++;
      end
      default: if (rise) begin
        m_s1 = 0; m_s2 = 0; m_p1 = 255; m_p2 = 255;
        m_bx = 460; m_by = 271; m_dx = 1; m_serve_dir = 1; m_state = 0;
      end
    endcase
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("paddle1_y", paddle1_y, m_p1);
      chk("paddle2_y", paddle2_y, m_p2);
      chk("ball_x", ball_x, m_bx);
      chk("ball_y", ball_y, m_by);
      chk("score", score, m_s1 * 256 + m_s2);
      chk("game_state", game_state, m_state);
    end
  end

  task automatic cyc(input bit fr, input bit u1, input bit d1,
                     input bit u2, input bit d2, input bit sv);
    @(negedge clk);
    frame_tick = fr; up1 = u1; down1 = d1; up2 = u2; down2 = d2; serve = sv;
    @(posedge clk);
    model_step(fr, u1, d1, u2, d2, sv);
    #1;
  endtask

  initial begin
    bit fr, u1, d1, u2, d2, sv;
    int prev_state;
    model_reset();
    m_valid = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_paddle1", paddle1_y, 255);
    chk("rst_paddle2", paddle2_y, 255);
    chk("rst_ball_x", ball_x, 460);
    chk("rst_ball_y", ball_y, 271);
    chk("rst_score", score, 16'h0000);
    chk("rst_state", game_state, 0);
    rst = 1'b0;

    cyc(1, 1, 0, 0, 0, 0);
    chk("pin_p1_up", paddle1_y, 253);
    chk("pin_serve_idle", game_state, 0);

    cyc(1, 0, 0, 0, 1, 1);
    chk("pin_serve_state", game_state, 1);
    chk("pin_no_motion_x", ball_x, 460);
    chk("pin_no_motion_y", ball_y, 271);
`ifdef PONG_AI_EN
    chk("pin_p2_ai_hold", paddle2_y, 255);
`else
    chk("pin_p2_down", paddle2_y, 257);
`endif

    cyc(1, 0, 0, 0, 0, 1);
    chk("pin_first_move_x", ball_x, 462);
    chk("pin_first_move_y", ball_y, 273);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("pin_second_move_x", ball_x, 464);
    chk("pin_still_play", game_state, 1);

    // Asynchronous reset in the middle of a rally
    #2;
    rst = 1'b1;
    frame_tick = 0; up1 = 0; down1 = 0; up2 = 0; down2 = 0; serve = 0;
    #1;
    chk("async_rst_state", game_state, 0);
    chk("async_rst_ball_x", ball_x, 460);
    chk("async_rst_ball_y", ball_y, 271);
    chk("async_rst_paddle1", paddle1_y, 255);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    cyc(0, 0, 0, 0, 0, 1);
    repeat (5) cyc(1, 1, 1, 0, 0, 0);
    chk("pin_both_hold", paddle1_y, 255);
    repeat (200) cyc(1, 1, 0, 0, 0, 0);
    chk("pin_p1_floor", paddle1_y, 35);

    sv = 1'b0;
    prev_state = m_state;
    for (int i = 0; i < 50000; i++) begin
      fr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) begin
        u1 = (m_by + 4 < m_p1 + 16);
        d1 = (m_by + 4 > m_p1 + 24);
      end else begin
        u1 = 1'($urandom_range(0, 1));
        d1 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) != 0) begin
        u2 = (m_by + 4 < m_p2 + 16);
        d2 = (m_by + 4 > m_p2 + 24);
      end else begin
        u2 = 1'($urandom_range(0, 1));
        d2 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 40) == 0) sv = !sv;
      cyc(fr, u1, d1, u2, d2, sv);
      if (m_state == 3 && prev_state != 3)
        chk("game_over_has_9", int'(score[11:8] == 4'd9 || score[3:0] == 4'd9), 1);
      prev_state = m_state;
    end

    m_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
